// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with a valid/ready handshake, synchronous flush,
// and an optional 2-entry skid buffer that registers in_ready.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  // State encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  if (SKID == 1) begin : g_skid
    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nx;
    end

    always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nx       = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nx     = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_nx  = TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nx       = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
      // Flush wins over everything; held data stays in the registers but is no longer valid.
      if (flush) begin
        state_nx       = EMPTY;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
      end
    end

    // NOTE: payload registers are reset too, so out_data is a known zero after reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (load_main_in)        main_q <= in_data;
        else if (load_main_skid) main_q <= skid_q;
        if (load_skid)           skid_q <= in_data;
      end
    end

    // in_ready comes from registered state only: no path from out_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;
  end else if (SKID == 0) begin : g_single
    logic              valid_q;
    logic [DATA_W-1:0] main_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)         valid_q <= 1'b0;
      else if (flush)    valid_q <= 1'b0;
      else if (in_fire)  valid_q <= 1'b1;
      else if (out_fire) valid_q <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                 main_q <= '0;
      else if (in_fire && !flush) main_q <= in_data;
    end

    // Accept when empty or when the held entry leaves this same cycle.
    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occupancy = {1'b0, valid_q};
  end else begin : g_bad_param
    $error("pipe_stage_buf: SKID must be 0 or 1, got %0d", SKID);
    assign in_ready  = 1'b0;
    assign out_valid = 1'b0;
    assign out_data  = '0;
    assign occupancy = '0;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: SKID=1 instance (a_*) and SKID=0 instance (b_*)
// share clock and reset; expected values are hand-computed per step.
module tb_pipe_stage_buf;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occupancy;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .SKID(1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .flush     (a_flush),
    .occupancy (a_occupancy)
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .flush     (b_flush),
    .occupancy (b_occupancy)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the SKID=1 instance: out_valid, out_data (only when valid expected), occupancy, in_ready.
  task automatic check_a(input string tag, input logic ov, input logic [DW-1:0] od,
                         input logic [1:0] occ, input logic ir);
    check({tag, ".out_valid"}, DW'(a_out_valid), DW'(ov));
    if (ov) check({tag, ".out_data"}, a_out_data, od);
    check({tag, ".occupancy"}, DW'(a_occupancy), DW'(occ));
    check({tag, ".in_ready"}, DW'(a_in_ready), DW'(ir));
  endtask

  task automatic check_b(input string tag, input logic ov, input logic [DW-1:0] od,
                         input logic [1:0] occ, input logic ir);
    check({tag, ".out_valid"}, DW'(b_out_valid), DW'(ov));
    if (ov) check({tag, ".out_data"}, b_out_data, od);
    check({tag, ".occupancy"}, DW'(b_occupancy), DW'(occ));
    check({tag, ".in_ready"}, DW'(b_in_ready), DW'(ir));
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    a_in_valid  = iv;
    a_in_data   = d;
    a_out_ready = ordy;
    a_flush     = fl;
    #1;
  endtask

  task automatic drive_b(input logic iv, input logic [DW-1:0] d, input logic ordy);
    b_in_valid  = iv;
    b_in_data   = d;
    b_out_ready = ordy;
    b_flush     = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive_a(1'b0, 'x, 1'b0, 1'b0);
    drive_b(1'b0, 'x, 1'b0);
    check_a("reset_a", 1'b0, '0, 2'd0, 1'b1);
    check("reset_a.data", a_out_data, '0);
    check_b("reset_b", 1'b0, '0, 2'd0, 1'b1);
    check("reset_b.data", b_out_data, '0);
    tick();
    reset = 1'b0;
    tick();

    // 1: streaming 1..8 with out_ready=1; output lags input by one cycle.
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, DW'(i), 1'b1, 1'b0);
      if (i == 1) check_a("stream_first", 1'b0, '0, 2'd0, 1'b1);
      else        check_a($sformatf("stream_%0d", i), 1'b1, DW'(i - 1), 2'd1, 1'b1);
      tick();
    end
    drive_a(1'b0, 'x, 1'b1, 1'b0);
    check_a("stream_last", 1'b1, 64'd8, 2'd1, 1'b1);
    tick();
    check_a("stream_drained", 1'b0, '0, 2'd0, 1'b1);

    // 2: backpressure. A then B with out_ready=0 fills both entries.
    drive_a(1'b1, 64'hA, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 64'hB, 1'b0, 1'b0);
    check_a("bp_one", 1'b1, 64'hA, 2'd1, 1'b1);
    tick();
    drive_a(1'b1, 64'hC, 1'b0, 1'b0);
    check_a("bp_full", 1'b1, 64'hA, 2'd2, 1'b0);
    tick();
    drive_a(1'b1, 64'hC, 1'b1, 1'b0);
    check_a("bp_held", 1'b1, 64'hA, 2'd2, 1'b0);
    tick();
    drive_a(1'b1, 64'hC, 1'b1, 1'b0);
    check_a("bp_b", 1'b1, 64'hB, 2'd1, 1'b1);
    tick();
    drive_a(1'b0, 'x, 1'b1, 1'b0);
    check_a("bp_c", 1'b1, 64'hC, 2'd1, 1'b1);
    tick();
    check_a("bp_drained", 1'b0, '0, 2'd0, 1'b1);

    // 3: flush with both entries held and D offered in the same cycle.
    drive_a(1'b1, 64'h21, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 64'h22, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 64'hD, 1'b0, 1'b1);
    check_a("flush_pre", 1'b1, 64'h21, 2'd2, 1'b0);
    tick();
    drive_a(1'b1, 64'hD, 1'b0, 1'b1);
    check_a("flush_post", 1'b0, '0, 2'd0, 1'b1);
    tick();
    drive_a(1'b0, 'x, 1'b1, 1'b0);
    check_a("flush_no_d", 1'b0, '0, 2'd0, 1'b1);
    tick();

    // 4: flush in the same cycle as out_fire on A; skid entry B must vanish.
    drive_a(1'b1, 64'h41, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 64'h42, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, 'x, 1'b1, 1'b1);
    check_a("flush_fire_pre", 1'b1, 64'h41, 2'd2, 1'b0);
    tick();
    drive_a(1'b0, 'x, 1'b1, 1'b0);
    check_a("flush_fire_post", 1'b0, '0, 2'd0, 1'b1);
    tick();
    check_a("flush_fire_no_b", 1'b0, '0, 2'd0, 1'b1);

    // 5: SKID=0, continuous input, out_ready 1,0,1,0,1; in_ready follows out_ready while full.
    drive_b(1'b1, 64'h51, 1'b1);
    check_b("s0_empty", 1'b0, '0, 2'd0, 1'b1);
    tick();
    drive_b(1'b1, 64'h52, 1'b0);
    check_b("s0_stall", 1'b1, 64'h51, 2'd1, 1'b0);
    tick();
    drive_b(1'b1, 64'h52, 1'b1);
    check_b("s0_pass", 1'b1, 64'h51, 2'd1, 1'b1);
    tick();
    drive_b(1'b1, 64'h53, 1'b0);
    check_b("s0_stall2", 1'b1, 64'h52, 2'd1, 1'b0);
    tick();
    drive_b(1'b1, 64'h53, 1'b1);
    check_b("s0_pass2", 1'b1, 64'h52, 2'd1, 1'b1);
    tick();
    drive_b(1'b0, 'x, 1'b1);
    check_b("s0_last", 1'b1, 64'h53, 2'd1, 1'b1);
    tick();
    check_b("s0_drained", 1'b0, '0, 2'd0, 1'b1);

    // 6: async reset between edges with two entries held.
    drive_a(1'b1, 64'h61, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 64'h62, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, 'x, 1'b0, 1'b0);
    check_a("rst_pre", 1'b1, 64'h61, 2'd2, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_a("rst_async", 1'b0, '0, 2'd0, 1'b1);
    check("rst_async.data", a_out_data, '0);
    tick();
    #2;
    reset = 1'b0;
    tick();
    drive_a(1'b1, 64'h63, 1'b1, 1'b0);
    check_a("rst_after", 1'b0, '0, 2'd0, 1'b1);
    tick();
    drive_a(1'b0, 'x, 1'b1, 1'b0);
    check_a("rst_first", 1'b1, 64'h63, 2'd1, 1'b1);
    tick();
    check_a("rst_drained", 1'b0, '0, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
